// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the microcode sequencer: opcodes, micro-step
// encodings, control-word bit positions and the all-inactive control word.
package cpu_ctrl_pkg;

    localparam int SEQ_STEP_W   = 3;
    localparam int SEQ_OPCODE_W = 4;

    // Micro-step encodings; 5..7 are illegal and recover to T0.
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Opcodes; 0x9..0xD decode as NOP.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control-word layout.
    localparam int CW_W = 16;
    typedef logic [CW_W-1:0] cw_t;
    typedef logic [3:0]      cw_idx_t;

    localparam cw_idx_t CW_CE   = 4'd0;
    localparam cw_idx_t CW_CO_N = 4'd1;
    localparam cw_idx_t CW_J_N  = 4'd2;
    localparam cw_idx_t CW_MI_N = 4'd3;
    localparam cw_idx_t CW_RI_N = 4'd4;
    localparam cw_idx_t CW_RO_N = 4'd5;
    localparam cw_idx_t CW_II_N = 4'd6;
    localparam cw_idx_t CW_IO_N = 4'd7;
    localparam cw_idx_t CW_AI_N = 4'd8;
    localparam cw_idx_t CW_AO_N = 4'd9;
    localparam cw_idx_t CW_BI_N = 4'd10;
    localparam cw_idx_t CW_EO_N = 4'd11;
    localparam cw_idx_t CW_SU   = 4'd12;
    localparam cw_idx_t CW_FI_N = 4'd13;
    localparam cw_idx_t CW_OI_N = 4'd14;
    localparam cw_idx_t CW_HLT  = 4'd15;

    // Every strobe at its inactive level: active-low bits high, ce/su/hlt low.
    localparam cw_t CW_INACTIVE = ~((cw_t'(1) << CW_CE) | (cw_t'(1) << CW_SU) |
                                    (cw_t'(1) << CW_HLT));

    // Drive one strobe to its active level, whatever its polarity.
    function automatic cw_t cw_on(input cw_t cw, input cw_idx_t idx);
        cw_t r;
        r      = cw;
        r[idx] = ~CW_INACTIVE[idx];
        return r;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the instruction/flags side and the sequencer's control word.
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [SEQ_OPCODE_W-1:0] opcode;
    logic                    carry_flag;
    logic                    zero_flag;
    logic ce, co_n, j_n, mi_n, ri_n, ro_n, ii_n, io_n;
    logic ai_n, ao_n, bi_n, eo_n, su, fi_n, oi_n, hlt;
    logic [SEQ_STEP_W-1:0]   step;

    modport master (
        output opcode, carry_flag, zero_flag,
        input  ce, co_n, j_n, mi_n, ri_n, ro_n, ii_n, io_n,
        input  ai_n, ao_n, bi_n, eo_n, su, fi_n, oi_n, hlt, step
    );

    modport slave (
        input  opcode, carry_flag, zero_flag,
        output ce, co_n, j_n, mi_n, ri_n, ro_n, ii_n, io_n,
        output ai_n, ao_n, bi_n, eo_n, su, fi_n, oi_n, hlt, step
    );

endinterface

// File: rtl/step_counter.sv
// Micro-step counter: advances each clock, restarts after an instruction's
// last step, holds while halted, and falls back to T0 from illegal codes.
module step_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int STEP_W = SEQ_STEP_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              restart,
    input  logic              hold,
    output logic [STEP_W-1:0] step
);

    // Step register; illegal recovery outranks hold and restart.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            step <= '0;
        else if (step > STEP_W'(T4))
            step <= '0;
        else if (hold)
            step <= step;
        else if (restart)
            step <= '0;
        else
            step <= step + STEP_W'(1);
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: decodes opcode, flags and micro-step into the CPU's
// control word, ending each instruction at its own last step and latching halt.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int STEP_W   = SEQ_STEP_W,
    parameter int OPCODE_W = SEQ_OPCODE_W
) (
    input logic                clk,
    input logic                clr,
    control_sequencer_if.slave bus
);

    logic [STEP_W-1:0]   step_q;
    logic [OPCODE_W-1:0] op;
    logic                halted;
    logic                last_step;
    logic                halt_now;
    cw_t                 cw;

    assign op = bus.opcode;

    step_counter #(.STEP_W(STEP_W)) u_step_counter (
        .clk     (clk),
        .clr     (clr),
        .restart (last_step),
        .hold    (halted | halt_now),
        .step    (step_q)
    );

    // Halted flag: set by HLT in T2, cleared only by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            halted <= 1'b0;
        else if (halt_now)
            halted <= 1'b1;
    end

    // Next-state decode: which step closes the current instruction.
    always_comb begin
        last_step = 1'b0;
        halt_now  = 1'b0;
        if (!halted) begin
            case (step_q)
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: last_step = 1'b0;
                        OP_HLT:                         halt_now  = 1'b1;
                        default:                        last_step = 1'b1;
                    endcase
                end
                T3: last_step = !(op == OP_ADD || op == OP_SUB);
                T4: last_step = 1'b1;
                default: last_step = 1'b0;
            endcase
        end
    end

    // Output decode: control word from step, halted, opcode and flags.
    always_comb begin
        cw = CW_INACTIVE;
        if (halted) begin
            cw = cw_on(cw, CW_HLT);
        end else begin
            case (step_q)
                T0: begin
                    cw = cw_on(cw, CW_CO_N);
                    cw = cw_on(cw, CW_MI_N);
                end
                T1: begin
                    cw = cw_on(cw, CW_RO_N);
                    cw = cw_on(cw, CW_II_N);
                    cw = cw_on(cw, CW_CE);
                end
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            cw = cw_on(cw, CW_IO_N);
                            cw = cw_on(cw, CW_MI_N);
                        end
                        OP_LDI: begin
                            cw = cw_on(cw, CW_IO_N);
                            cw = cw_on(cw, CW_AI_N);
                        end
                        OP_JMP, OP_JC, OP_JZ: begin
                            if (op == OP_JMP || (op == OP_JC && bus.carry_flag) ||
                                (op == OP_JZ && bus.zero_flag)) begin
                                cw = cw_on(cw, CW_IO_N);
                                cw = cw_on(cw, CW_J_N);
                            end
                        end
                        OP_OUT: begin
                            cw = cw_on(cw, CW_AO_N);
                            cw = cw_on(cw, CW_OI_N);
                        end
                        OP_HLT:  cw = cw_on(cw, CW_HLT);
                        default: cw = CW_INACTIVE;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA: begin
                            cw = cw_on(cw, CW_RO_N);
                            cw = cw_on(cw, CW_AI_N);
                        end
                        OP_ADD, OP_SUB: begin
                            cw = cw_on(cw, CW_RO_N);
                            cw = cw_on(cw, CW_BI_N);
                        end
                        OP_STA: begin
                            cw = cw_on(cw, CW_AO_N);
                            cw = cw_on(cw, CW_RI_N);
                        end
                        default: cw = CW_INACTIVE;
                    endcase
                end
                T4: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        cw = cw_on(cw, CW_EO_N);
                        cw = cw_on(cw, CW_AI_N);
                        cw = cw_on(cw, CW_FI_N);
                        if (op == OP_SUB)
                            cw = cw_on(cw, CW_SU);
                    end
                end
                default: cw = CW_INACTIVE;
            endcase
        end
    end

    assign bus.ce   = cw[CW_CE];
    assign bus.co_n = cw[CW_CO_N];
    assign bus.j_n  = cw[CW_J_N];
    assign bus.mi_n = cw[CW_MI_N];
    assign bus.ri_n = cw[CW_RI_N];
    assign bus.ro_n = cw[CW_RO_N];
    assign bus.ii_n = cw[CW_II_N];
    assign bus.io_n = cw[CW_IO_N];
    assign bus.ai_n = cw[CW_AI_N];
    assign bus.ao_n = cw[CW_AO_N];
    assign bus.bi_n = cw[CW_BI_N];
    assign bus.eo_n = cw[CW_EO_N];
    assign bus.su   = cw[CW_SU];
    assign bus.fi_n = cw[CW_FI_N];
    assign bus.oi_n = cw[CW_OI_N];
    assign bus.hlt  = cw[CW_HLT];
    assign bus.step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instruction sequences push
// hand-written per-cycle expectations; a monitor pops and compares them.
module tb_control_sequencer;

    // Asserted-strobe masks in bench bit order {hlt,oi,fi,su,eo,bi,ao,ai,io,ii,ro,ri,mi,j,co,ce}.
    localparam logic [15:0] S_NONE = 16'h0000;
    localparam logic [15:0] S_CE   = 16'h0001;
    localparam logic [15:0] S_CO   = 16'h0002;
    localparam logic [15:0] S_J    = 16'h0004;
    localparam logic [15:0] S_MI   = 16'h0008;
    localparam logic [15:0] S_RI   = 16'h0010;
    localparam logic [15:0] S_RO   = 16'h0020;
    localparam logic [15:0] S_II   = 16'h0040;
    localparam logic [15:0] S_IO   = 16'h0080;
    localparam logic [15:0] S_AI   = 16'h0100;
    localparam logic [15:0] S_AO   = 16'h0200;
    localparam logic [15:0] S_BI   = 16'h0400;
    localparam logic [15:0] S_EO   = 16'h0800;
    localparam logic [15:0] S_SU   = 16'h1000;
    localparam logic [15:0] S_FI   = 16'h2000;
    localparam logic [15:0] S_OI   = 16'h4000;
    localparam logic [15:0] S_HLT  = 16'h8000;
    // Levels with nothing asserted: active-low strobes high, ce/su/hlt low.
    localparam logic [15:0] IDLE   = 16'h6FFE;

    localparam logic [15:0] FETCH0 = S_CO | S_MI;
    localparam logic [15:0] FETCH1 = S_RO | S_II | S_CE;

    typedef struct {
        logic [2:0]  stp;
        logic [15:0] cw;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic clr = 1'b1;

    control_sequencer_if bus_if ();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    wire [15:0] got_cw = {bus_if.hlt, bus_if.oi_n, bus_if.fi_n, bus_if.su,
                          bus_if.eo_n, bus_if.bi_n, bus_if.ao_n, bus_if.ai_n,
                          bus_if.io_n, bus_if.ii_n, bus_if.ro_n, bus_if.ri_n,
                          bus_if.mi_n, bus_if.j_n, bus_if.co_n, bus_if.ce};

    task automatic push(input logic [2:0] stp, input logic [15:0] mask, input string name);
        exp_t e;
        e.stp  = stp;
        e.cw   = mask ^ IDLE;
        e.name = name;
        sb.push_back(e);
    endtask

    // One clock: after the edge, apply inputs and record the expected output.
    task automatic tick(input logic [3:0] op, input logic c, input logic z,
                        input logic [2:0] stp, input logic [15:0] mask, input string name);
        @(posedge clk);
        #1;
        bus_if.opcode     = op;
        bus_if.carry_flag = c;
        bus_if.zero_flag  = z;
        push(stp, mask, name);
    endtask

    // Full fetch (T0, T1) for an instruction.
    task automatic fetch(input logic [3:0] op, input logic c, input logic z, input string name);
        tick(op, c, z, 3'd0, FETCH0, {name, "_t0"});
        tick(op, c, z, 3'd1, FETCH1, {name, "_t1"});
    endtask

    task automatic check_one();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus_if.step !== e.stp || got_cw !== e.cw) begin
                errors++;
                $display("FAIL %s: got step=%0d cw=%h, expected step=%0d cw=%h",
                         e.name, bus_if.step, got_cw, e.stp, e.cw);
            end
        end
    endtask

    // Monitor: samples at the falling edge and again just before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            check_one();
            #3;
            check_one();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.opcode     = 4'h0;
        bus_if.carry_flag = 1'b0;
        bus_if.zero_flag  = 1'b0;

        // Reset held across edges: fetch strobes of T0 only.
        tick(4'h2, 0, 0, 3'd0, FETCH0, "rst_a");
        tick(4'h2, 0, 0, 3'd0, FETCH0, "rst_b");
        clr = 1'b0;

        // ADD: 5 steps, su inactive.
        tick(4'h2, 0, 0, 3'd1, FETCH1, "add_t1");
        tick(4'h2, 0, 0, 3'd2, S_IO | S_MI, "add_t2");
        tick(4'h2, 0, 0, 3'd3, S_RO | S_BI, "add_t3");
        tick(4'h2, 0, 0, 3'd4, S_EO | S_AI | S_FI, "add_t4");

        // SUB: su only in T4.
        fetch(4'h3, 0, 0, "sub");
        tick(4'h3, 0, 0, 3'd2, S_IO | S_MI, "sub_t2");
        tick(4'h3, 0, 0, 3'd3, S_RO | S_BI, "sub_t3");
        tick(4'h3, 0, 0, 3'd4, S_EO | S_AI | S_FI | S_SU, "sub_t4");

        // LDI: 3 steps.
        fetch(4'h5, 0, 0, "ldi");
        tick(4'h5, 0, 0, 3'd2, S_IO | S_AI, "ldi_t2");

        // JC not taken, with carry high outside T2.
        fetch(4'h7, 1, 0, "jc0");
        tick(4'h7, 0, 0, 3'd2, S_NONE, "jc0_t2");
        // JC taken, carry raised only in T2.
        fetch(4'h7, 0, 0, "jc1");
        tick(4'h7, 1, 0, 3'd2, S_IO | S_J, "jc1_t2");

        // JZ pair; carry is irrelevant here.
        fetch(4'h8, 1, 1, "jz0");
        tick(4'h8, 1, 0, 3'd2, S_NONE, "jz0_t2");
        fetch(4'h8, 0, 0, "jz1");
        tick(4'h8, 0, 1, 3'd2, S_IO | S_J, "jz1_t2");

        // JMP unconditional.
        fetch(4'h6, 0, 0, "jmp");
        tick(4'h6, 0, 0, 3'd2, S_IO | S_J, "jmp_t2");

        // Unused opcode behaves as a 3-step NOP.
        fetch(4'hB, 1, 1, "nopb");
        tick(4'hB, 1, 1, 3'd2, S_NONE, "nopb_t2");

        // STA then LDA back to back, then OUT.
        fetch(4'h4, 0, 0, "sta");
        tick(4'h4, 0, 0, 3'd2, S_IO | S_MI, "sta_t2");
        tick(4'h4, 0, 0, 3'd3, S_AO | S_RI, "sta_t3");
        fetch(4'h1, 0, 0, "lda");
        tick(4'h1, 0, 0, 3'd2, S_IO | S_MI, "lda_t2");
        tick(4'h1, 0, 0, 3'd3, S_RO | S_AI, "lda_t3");
        fetch(4'hE, 0, 0, "out");
        tick(4'hE, 0, 0, 3'd2, S_AO | S_OI, "out_t2");

        // ADD interrupted by clr in the middle of T3.
        fetch(4'h2, 0, 0, "addc");
        tick(4'h2, 0, 0, 3'd2, S_IO | S_MI, "addc_t2");
        tick(4'h2, 0, 0, 3'd3, S_RO | S_BI, "addc_t3");
        @(negedge clk);
        #1;
        clr = 1'b1;
        push(3'd0, FETCH0, "clr_async");
        tick(4'h2, 0, 0, 3'd0, FETCH0, "clr_hold");
        clr = 1'b0;
        tick(4'h2, 0, 0, 3'd1, FETCH1, "addc_restart_t1");

        // HLT from a clean start.
        @(negedge clk);
        #1;
        clr = 1'b1;
        push(3'd0, FETCH0, "pre_hlt_clr");
        tick(4'hF, 0, 0, 3'd0, FETCH0, "hlt_t0");
        clr = 1'b0;
        tick(4'hF, 0, 0, 3'd1, FETCH1, "hlt_t1");
        tick(4'hF, 0, 0, 3'd2, S_HLT, "hlt_t2");
        for (int i = 0; i < 10; i++) begin
            logic [3:0] op;
            op = 4'(i + 1);
            tick(op, i[0], i[1], 3'd2, S_HLT, "halted");
        end
        @(negedge clk);
        #1;
        clr = 1'b1;
        push(3'd0, FETCH0, "hlt_release");
        tick(4'h0, 0, 0, 3'd0, FETCH0, "hlt_release_hold");
        clr = 1'b0;
        tick(4'h0, 0, 0, 3'd1, FETCH1, "post_hlt_t1");
        tick(4'h0, 0, 0, 3'd2, S_NONE, "post_hlt_t2");
        tick(4'h0, 0, 0, 3'd0, FETCH0, "post_hlt_t0");

        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
